// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the pipeline
// control unit.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    typedef struct packed {
        logic       alu_src;
        logic [2:0] alu_op;
        logic       branch;
        logic       branch_ne;
    } ex_ctl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic link;
    } wb_ctl_t;

    // Grouped per consuming stage so later pipeline registers keep only
    // the fields still needed downstream.
    typedef struct packed {
        ex_ctl_t  ex;
        mem_ctl_t mem;
        wb_ctl_t  wb;
    } ctl_t;

    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the MIPS datapath (master) and the pipeline
// control unit (slave).
interface pipe_ctrl_if #(parameter int REG_AW = 5);

    logic              id_valid;
    logic [5:0]        id_op;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              ex_branch_taken;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              id_jump;
    logic              ex_alu_src;
    logic [2:0]        ex_alu_op;
    logic              ex_branch;
    logic              ex_branch_ne;
    logic              mem_read;
    logic              mem_write;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic              wb_link;
    logic [REG_AW-1:0] wb_dst;

    modport master (
        output id_valid, id_op, id_rs, id_rt, id_rd, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush, id_jump,
        input  ex_alu_src, ex_alu_op, ex_branch, ex_branch_ne,
        input  mem_read, mem_write,
        input  wb_reg_write, wb_mem_to_reg, wb_link, wb_dst
    );

    modport slave (
        input  id_valid, id_op, id_rs, id_rt, id_rd, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush, id_jump,
        output ex_alu_src, ex_alu_op, ex_branch, ex_branch_ne,
        output mem_read, mem_write,
        output wb_reg_write, wb_mem_to_reg, wb_link, wb_dst
    );

endinterface

// File: rtl/pipe_ctrl_decode.sv
// Combinational ID-stage decode: opcode to control bundle, destination
// register and source-register usage.
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter bit EXT_OPS = 1'b1
) (
    input  logic              valid,
    input  logic [5:0]        op,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output ctl_t              ctl,
    output logic              jump,
    output logic [REG_AW-1:0] dst,
    output logic              uses_rs,
    output logic              uses_rt
);

    always_comb begin
        ctl     = '0;
        jump    = 1'b0;
        dst     = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        if (valid) begin
            uses_rs = !is_jump_op(op);
            uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
            case (op)
                OP_RTYPE: begin
                    ctl.wb.reg_write = 1'b1;
                    ctl.ex.alu_op    = ALU_FUNCT;
                    dst              = rd;
                end
                OP_LW: begin
                    ctl.ex.alu_src    = 1'b1;
                    ctl.mem.mem_read  = 1'b1;
                    ctl.wb.mem_to_reg = 1'b1;
                    ctl.wb.reg_write  = 1'b1;
                    ctl.ex.alu_op     = ALU_ADD;
                    dst               = rt;
                end
                OP_SW: begin
                    ctl.ex.alu_src    = 1'b1;
                    ctl.mem.mem_write = 1'b1;
                    ctl.ex.alu_op     = ALU_ADD;
                end
                OP_BEQ: begin
                    ctl.ex.branch = 1'b1;
                    ctl.ex.alu_op = ALU_SUB;
                end
                OP_J: jump = 1'b1;
                default: begin
                    // Extended opcodes decode as a bubble on minimal cores.
                    if (EXT_OPS) begin
                        case (op)
                            OP_BNE: begin
                                ctl.ex.branch    = 1'b1;
                                ctl.ex.branch_ne = 1'b1;
                                ctl.ex.alu_op    = ALU_SUB;
                            end
                            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                                ctl.ex.alu_src   = 1'b1;
                                ctl.wb.reg_write = 1'b1;
                                dst              = rt;
                                case (op)
                                    OP_ANDI: ctl.ex.alu_op = ALU_AND;
                                    OP_ORI:  ctl.ex.alu_op = ALU_OR;
                                    OP_SLTI: ctl.ex.alu_op = ALU_SLT;
                                    default: ctl.ex.alu_op = ALU_ADD;
                                endcase
                            end
                            OP_JAL: begin
                                jump             = 1'b1;
                                ctl.wb.reg_write = 1'b1;
                                ctl.wb.link      = 1'b1;
                                dst              = REG_AW'(31);
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: ID decode carried through ID/EX, EX/MEM and MEM/WB,
// plus load-use stall and branch/jump flush generation.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter bit EXT_OPS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);

    ctl_t              id_ctl;
    logic              id_jump_raw;
    logic [REG_AW-1:0] id_dst;
    logic              uses_rs;
    logic              uses_rt;

    ctl_t              idex_ctl;
    logic [REG_AW-1:0] idex_dst;
    mem_ctl_t          exmem_mem;
    wb_ctl_t           exmem_wb;
    logic [REG_AW-1:0] exmem_dst;
    wb_ctl_t           memwb_wb;
    logic [REG_AW-1:0] memwb_dst;

    logic              load_use;
    logic              stall;

    pipe_ctrl_decode #(
        .REG_AW  (REG_AW),
        .EXT_OPS (EXT_OPS)
    ) u_decode (
        .valid   (bus.id_valid),
        .op      (bus.id_op),
        .rt      (bus.id_rt),
        .rd      (bus.id_rd),
        .ctl     (id_ctl),
        .jump    (id_jump_raw),
        .dst     (id_dst),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt)
    );

    assign load_use = idex_ctl.mem.mem_read && (idex_dst != '0) &&
                      ((uses_rs && (idex_dst == bus.id_rs)) ||
                       (uses_rt && (idex_dst == bus.id_rt)));
    // A taken branch squashes the dependent instruction anyway, so it wins.
    assign stall = load_use && !bus.ex_branch_taken;

    always_comb begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.id_jump    = 1'b0;
        if (!rst_n) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.ifid_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
            bus.ifid_flush = 1'b1;
            bus.id_jump    = id_jump_raw;
        end else if (stall) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
        end else begin
            bus.id_jump    = id_jump_raw;
            bus.ifid_flush = id_jump_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_ctl  <= '0;
            idex_dst  <= '0;
            exmem_mem <= '0;
            exmem_wb  <= '0;
            exmem_dst <= '0;
            memwb_wb  <= '0;
            memwb_dst <= '0;
        end else begin
            if (bus.ex_branch_taken || stall) begin
                idex_ctl <= '0;
                idex_dst <= '0;
            end else begin
                idex_ctl <= id_ctl;
                idex_dst <= id_dst;
            end
            exmem_mem <= idex_ctl.mem;
            exmem_wb  <= idex_ctl.wb;
            exmem_dst <= idex_dst;
            memwb_wb  <= exmem_wb;
            memwb_dst <= exmem_dst;
        end
    end

    assign bus.ex_alu_src    = idex_ctl.ex.alu_src;
    assign bus.ex_alu_op     = idex_ctl.ex.alu_op;
    assign bus.ex_branch     = idex_ctl.ex.branch;
    assign bus.ex_branch_ne  = idex_ctl.ex.branch_ne;
    assign bus.mem_read      = exmem_mem.mem_read;
    assign bus.mem_write     = exmem_mem.mem_write;
    assign bus.wb_reg_write  = memwb_wb.reg_write;
    assign bus.wb_mem_to_reg = memwb_wb.mem_to_reg;
    assign bus.wb_link       = memwb_wb.link;
    assign bus.wb_dst        = memwb_dst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: decode table, hand-written hazard
// sequences, and randomized traffic against a behavioural pipeline model.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       taken;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.REG_AW(5)) bus1 ();
    pipe_ctrl_if #(.REG_AW(5)) bus0 ();

    assign bus1.id_valid = id_valid;
    assign bus1.id_op    = id_op;
    assign bus1.id_rs    = id_rs;
    assign bus1.id_rt    = id_rt;
    assign bus1.id_rd    = id_rd;
    assign bus1.ex_branch_taken = taken;
    assign bus0.id_valid = id_valid;
    assign bus0.id_op    = id_op;
    assign bus0.id_rs    = id_rs;
    assign bus0.id_rt    = id_rt;
    assign bus0.id_rd    = id_rd;
    assign bus0.ex_branch_taken = taken;

    pipe_ctrl #(.REG_AW(5), .EXT_OPS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    pipe_ctrl #(.REG_AW(5), .EXT_OPS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic       src;
        logic [2:0] alu;
        logic       br, bne, jmp, mr, mw, rw, m2r, lnk;
        logic [4:0] dst;
        logic       urs, urt;
    } ref_t;

    ref_t m_ex  = '0;
    ref_t m_mem = '0;
    ref_t m_wb  = '0;

    function automatic ref_t ref_decode(input logic v, input logic [5:0] op,
                                        input logic [4:0] rt, input logic [4:0] rd);
        ref_t r = '0;
        if (!v) return r;
        r.urs = (op != 6'd2) && (op != 6'd3);
        r.urt = (op == 6'd0) || (op == 6'd43) || (op == 6'd4) || (op == 6'd5);
        case (op)
            6'd0:  begin r.rw = 1; r.dst = rd; r.alu = 3'd2; end
            6'd35: begin r.src = 1; r.mr = 1; r.m2r = 1; r.rw = 1; r.dst = rt; end
            6'd43: begin r.src = 1; r.mw = 1; end
            6'd4:  begin r.br = 1; r.alu = 3'd1; end
            6'd5:  begin r.br = 1; r.bne = 1; r.alu = 3'd1; end
            6'd8:  begin r.src = 1; r.rw = 1; r.dst = rt; r.alu = 3'd0; end
            6'd12: begin r.src = 1; r.rw = 1; r.dst = rt; r.alu = 3'd3; end
            6'd13: begin r.src = 1; r.rw = 1; r.dst = rt; r.alu = 3'd4; end
            6'd10: begin r.src = 1; r.rw = 1; r.dst = rt; r.alu = 3'd5; end
            6'd2:  r.jmp = 1;
            6'd3:  begin r.jmp = 1; r.rw = 1; r.lnk = 1; r.dst = 5'd31; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic ref_stall(input ref_t d);
        return m_ex.mr && (m_ex.dst != 0) && !taken &&
               ((d.urs && m_ex.dst == id_rs) || (d.urt && m_ex.dst == id_rt));
    endfunction

    always @(posedge clk) begin
        ref_t d;
        d = ref_decode(id_valid, id_op, id_rt, id_rd);
        if (!rst_n) begin
            m_ex  <= '0;
            m_mem <= '0;
            m_wb  <= '0;
        end else begin
            m_wb  <= m_mem;
            m_mem <= m_ex;
            m_ex  <= (taken || ref_stall(d)) ? ref_t'('0) : d;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input int op, input int rs, input int rt, input int rd);
        id_valid = v;
        id_op    = 6'(op);
        id_rs    = 5'(rs);
        id_rt    = 5'(rt);
        id_rd    = 5'(rd);
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0);
        taken = 0;
        repeat (4) next();
    endtask

    logic exp_ifw;

    task automatic check_model();
        ref_t d;
        logic st, e_pc, e_fl, e_jmp;
        d     = ref_decode(id_valid, id_op, id_rt, id_rd);
        st    = ref_stall(d);
        e_pc  = !rst_n ? 1'b0 : taken ? 1'b1 : st ? 1'b0 : 1'b1;
        e_fl  = !rst_n ? 1'b1 : taken ? 1'b1 : st ? 1'b0 : d.jmp;
        e_jmp = rst_n && d.jmp && !st;
        exp_ifw = e_pc;
        chk("rnd_pc_write",   bus1.pc_write,      e_pc);
        chk("rnd_ifid_write", bus1.ifid_write,    e_pc);
        chk("rnd_ifid_flush", bus1.ifid_flush,    e_fl);
        chk("rnd_id_jump",    bus1.id_jump,       e_jmp);
        chk("rnd_ex_alu_src", bus1.ex_alu_src,    m_ex.src);
        chk("rnd_ex_alu_op",  bus1.ex_alu_op,     m_ex.alu);
        chk("rnd_ex_branch",  bus1.ex_branch,     m_ex.br);
        chk("rnd_ex_bne",     bus1.ex_branch_ne,  m_ex.bne);
        chk("rnd_mem_read",   bus1.mem_read,      m_mem.mr);
        chk("rnd_mem_write",  bus1.mem_write,     m_mem.mw);
        chk("rnd_wb_rw",      bus1.wb_reg_write,  m_wb.rw);
        chk("rnd_wb_m2r",     bus1.wb_mem_to_reg, m_wb.m2r);
        chk("rnd_wb_link",    bus1.wb_link,       m_wb.lnk);
        chk("rnd_wb_dst",     bus1.wb_dst,        m_wb.dst);
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        int op, rs, rt, rd;
        int jmp, src, alu, br, bne, mr, mw, rw, m2r, lnk, dst;
    } vec_t;

    vec_t tbl[12];
    int   ops[12] = '{0, 35, 43, 4, 5, 8, 12, 13, 10, 2, 3, 63};

    initial begin
        //           op  rs rt rd  jmp src alu br bne mr mw rw m2r lnk dst
        tbl[0]  = '{ 0,  1, 2, 7,  0,  0,  2,  0, 0,  0, 0, 1, 0,  0,  7};
        tbl[1]  = '{35,  1, 9, 4,  0,  1,  0,  0, 0,  1, 0, 1, 1,  0,  9};
        tbl[2]  = '{43,  1, 9, 4,  0,  1,  0,  0, 0,  0, 1, 0, 0,  0,  0};
        tbl[3]  = '{ 4,  1, 2, 3,  0,  0,  1,  1, 0,  0, 0, 0, 0,  0,  0};
        tbl[4]  = '{ 5,  1, 2, 3,  0,  0,  1,  1, 1,  0, 0, 0, 0,  0,  0};
        tbl[5]  = '{ 8,  1, 3, 6,  0,  1,  0,  0, 0,  0, 0, 1, 0,  0,  3};
        tbl[6]  = '{12,  1, 3, 6,  0,  1,  3,  0, 0,  0, 0, 1, 0,  0,  3};
        tbl[7]  = '{13,  1,11, 6,  0,  1,  4,  0, 0,  0, 0, 1, 0,  0, 11};
        tbl[8]  = '{10,  1,12, 6,  0,  1,  5,  0, 0,  0, 0, 1, 0,  0, 12};
        tbl[9]  = '{ 2,  1, 2, 3,  1,  0,  0,  0, 0,  0, 0, 0, 0,  0,  0};
        tbl[10] = '{ 3,  1, 2, 3,  1,  0,  0,  0, 0,  0, 0, 1, 0,  1, 31};
        tbl[11] = '{63,  1, 2, 3,  0,  0,  0,  0, 0,  0, 0, 0, 0,  0,  0};

        rst_n = 0;
        taken = 0;
        set_id(0, 0, 0, 0, 0);
        next();
        next();

        // reset state
        settle();
        chk("rst_pc_write",   bus1.pc_write,     0);
        chk("rst_ifid_write", bus1.ifid_write,   0);
        chk("rst_ifid_flush", bus1.ifid_flush,   1);
        chk("rst_ex_alu_op",  bus1.ex_alu_op,    0);
        chk("rst_mem_read",   bus1.mem_read,     0);
        chk("rst_wb_rw",      bus1.wb_reg_write, 0);
        chk("rst_wb_dst",     bus1.wb_dst,       0);
        chk("rst0_ifid_flush", bus0.ifid_flush,  1);
        next();
        rst_n = 1;
        settle();
        chk("post_rst_pc_write", bus1.pc_write,   1);
        chk("post_rst_flush",    bus1.ifid_flush, 0);
        next();

        // R-type rd=7 reaches WB exactly three edges later
        set_id(1, 0, 1, 2, 7);
        settle();
        chk("rtype_no_stall", bus1.pc_write,   1);
        chk("rtype_no_flush", bus1.ifid_flush, 0);
        next();
        set_id(0, 0, 0, 0, 0);
        next();
        settle();
        chk("rtype_wb_not_early", bus1.wb_reg_write, 0);
        next();
        settle();
        chk("rtype_wb_rw",  bus1.wb_reg_write, 1);
        chk("rtype_wb_dst", bus1.wb_dst,       7);
        drain();

        // table-driven decode through each stage
        for (int i = 0; i < 12; i++) begin
            set_id(1, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd);
            settle();
            chk($sformatf("tbl%0d_id_jump", i),  bus1.id_jump,    tbl[i].jmp);
            chk($sformatf("tbl%0d_flush", i),    bus1.ifid_flush, tbl[i].jmp);
            chk($sformatf("tbl%0d_pc_write", i), bus1.pc_write,   1);
            next();
            set_id(0, 0, 0, 0, 0);
            settle();
            chk($sformatf("tbl%0d_ex_src", i), bus1.ex_alu_src,   tbl[i].src);
            chk($sformatf("tbl%0d_ex_alu", i), bus1.ex_alu_op,    tbl[i].alu);
            chk($sformatf("tbl%0d_ex_br", i),  bus1.ex_branch,    tbl[i].br);
            chk($sformatf("tbl%0d_ex_bne", i), bus1.ex_branch_ne, tbl[i].bne);
            next();
            settle();
            chk($sformatf("tbl%0d_mem_rd", i), bus1.mem_read,  tbl[i].mr);
            chk($sformatf("tbl%0d_mem_wr", i), bus1.mem_write, tbl[i].mw);
            next();
            settle();
            chk($sformatf("tbl%0d_wb_rw", i),   bus1.wb_reg_write,  tbl[i].rw);
            chk($sformatf("tbl%0d_wb_m2r", i),  bus1.wb_mem_to_reg, tbl[i].m2r);
            chk($sformatf("tbl%0d_wb_link", i), bus1.wb_link,       tbl[i].lnk);
            chk($sformatf("tbl%0d_wb_dst", i),  bus1.wb_dst,        tbl[i].dst);
            next();
        end
        drain();

        // lw r5 then add using r5: one stall cycle, bubble, add one cycle late
        set_id(1, 35, 1, 5, 0);
        next();
        set_id(1, 0, 5, 6, 8);
        settle();
        chk("lu_pc_write",   bus1.pc_write,   0);
        chk("lu_ifid_write", bus1.ifid_write, 0);
        chk("lu_ifid_flush", bus1.ifid_flush, 0);
        next();
        settle();
        chk("lu_bubble_alu_op",  bus1.ex_alu_op,  0);
        chk("lu_bubble_alu_src", bus1.ex_alu_src, 0);
        chk("lu_load_in_mem",    bus1.mem_read,   1);
        chk("lu_stall_released", bus1.pc_write,   1);
        next();
        set_id(0, 0, 0, 0, 0);
        settle();
        chk("lu_add_late_ex", bus1.ex_alu_op, 2);
        drain();

        // load into r0 never stalls
        set_id(1, 35, 1, 0, 0);
        next();
        set_id(1, 0, 0, 0, 8);
        settle();
        chk("r0_no_stall_pc",   bus1.pc_write,   1);
        chk("r0_no_stall_ifid", bus1.ifid_write, 1);
        next();
        set_id(0, 0, 0, 0, 0);
        settle();
        chk("r0_add_in_ex", bus1.ex_alu_op, 2);
        drain();

        // taken branch beats a simultaneous load-use match
        set_id(1, 35, 1, 5, 0);
        next();
        set_id(1, 0, 5, 6, 8);
        taken = 1;
        settle();
        chk("br_flush",      bus1.ifid_flush, 1);
        chk("br_pc_write",   bus1.pc_write,   1);
        chk("br_ifid_write", bus1.ifid_write, 1);
        next();
        taken = 0;
        set_id(0, 0, 0, 0, 0);
        settle();
        chk("br_bubble_alu_op",  bus1.ex_alu_op,  0);
        chk("br_bubble_alu_src", bus1.ex_alu_src, 0);
        chk("br_load_in_mem",    bus1.mem_read,   1);
        drain();

        // chained loads stall once per dependent pair
        set_id(1, 35, 1, 5, 0);
        next();
        set_id(1, 35, 5, 6, 0);
        settle();
        chk("ld2_stall", bus1.pc_write, 0);
        next();
        settle();
        chk("ld2_release", bus1.pc_write, 1);
        next();
        set_id(1, 0, 6, 2, 9);
        settle();
        chk("ld3_stall", bus1.pc_write, 0);
        next();
        settle();
        chk("ld3_release", bus1.pc_write, 1);
        drain();

        // ori on the minimal decoder is a bubble all the way down
        set_id(1, 13, 1, 11, 0);
        settle();
        chk("ori0_pc_write", bus0.pc_write, 1);
        next();
        set_id(0, 0, 0, 0, 0);
        settle();
        chk("ori0_ex_alu_op",  bus0.ex_alu_op,  0);
        chk("ori0_ex_alu_src", bus0.ex_alu_src, 0);
        chk("ori1_ex_alu_op",  bus1.ex_alu_op,  4);
        next();
        settle();
        chk("ori0_mem", bus0.mem_read | bus0.mem_write, 0);
        next();
        settle();
        chk("ori0_wb_rw",  bus0.wb_reg_write, 0);
        chk("ori0_wb_dst", bus0.wb_dst,       0);
        chk("ori1_wb_dst", bus1.wb_dst,       11);
        drain();

        // reset mid-stall overrides everything at the next edge
        set_id(1, 35, 1, 5, 0);
        next();
        set_id(1, 0, 5, 6, 8);
        rst_n = 0;
        settle();
        chk("mrst_pc_write",   bus1.pc_write,   0);
        chk("mrst_ifid_write", bus1.ifid_write, 0);
        chk("mrst_ifid_flush", bus1.ifid_flush, 1);
        next();
        settle();
        chk("mrst_ex_src",   bus1.ex_alu_src,   0);
        chk("mrst_mem_read", bus1.mem_read,     0);
        chk("mrst_wb_rw",    bus1.wb_reg_write, 0);
        chk("mrst0_flush",   bus0.ifid_flush,   1);
        next();
        rst_n = 1;
        settle();
        chk("mrst_no_stall_after", bus1.pc_write, 1);
        drain();

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            settle();
            check_model();
            next();
            rst_n = ($urandom_range(0, 63) != 0);
            taken = ($urandom_range(0, 7) == 0);
            if (exp_ifw || !rst_n) begin
                set_id($urandom_range(0, 7) != 0, ops[$urandom_range(0, 11)],
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
